// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: owns the fetch PC, latches each fetched
// word with its PC, and applies stall, flush, redirect and syscall halt.
module fetch_stage #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   halt,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            pc,
  output logic                   id_valid,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_pc_plus4,
  output logic [31:0]            id_instr,
  output logic [5:0]             id_op,
  output logic [5:0]             id_func,
  output logic [4:0]             id_rt,
  output logic                   halted,
  output logic [31:0]            cycle_count,
  output logic [31:0]            stall_count,
  output logic [31:0]            flush_count
);

  logic [31:0] pc_plus4;
  logic        freeze;
  logic        squash;
  logic        stall_hit;
  logic        flush_hit;

  assign pc_plus4  = pc + 32'd4;
  assign freeze    = halted | halt;
  assign squash    = flush | redirect_valid;
  assign stall_hit = stall & ~redirect_valid & ~flush & ~halt;
  assign flush_hit = squash & ~halt;

  assign imem_addr = pc[IMEM_ADDR_W+1:2];
  assign id_op     = id_instr[31:26];
  assign id_func   = id_instr[5:0];
  assign id_rt     = id_instr[20:16];

  // IF: program counter and sticky halt; a redirect outranks a stall because
  // the redirecting instruction is older than the one being stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= PC_RESET;
      halted <= 1'b0;
    end else begin
      if (halt) halted <= 1'b1;
      if (!freeze) begin
        if (redirect_valid) pc <= redirect_pc & 32'hFFFF_FFFC;
        else if (!stall)    pc <= pc_plus4;
      end
    end
  end

  // IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid    <= 1'b0;
      id_instr    <= 32'h0;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
    end else if (freeze || squash) begin
      id_valid <= 1'b0;
      id_instr <= 32'h0;
    end else if (!stall) begin
      id_valid    <= 1'b1;
      id_instr    <= imem_rdata;
      id_pc       <= pc;
      id_pc_plus4 <= pc_plus4;
    end
  end

  // Stats counters, frozen once halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= 32'h0;
      stall_count <= 32'h0;
      flush_count <= 32'h0;
    end else if (!halted) begin
      cycle_count <= cycle_count + 32'd1;
      if (stall_hit) stall_count <= stall_count + 32'd1;
      if (flush_hit) flush_count <= flush_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed expected
// state per edge, monitors pop and compare after each edge or reset assertion.
module tb_fetch_stage;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        v;
    logic [31:0] instr;
    logic [31:0] idpc;
    logic [31:0] p4;
    logic        h;
    logic [31:0] cc;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: default reset PC
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0, halt = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata, pc, id_pc, id_pc_plus4, id_instr;
  logic        id_valid, halted;
  logic [5:0]  id_op, id_func;
  logic [4:0]  id_rt;
  logic [31:0] cycle_count, stall_count, flush_count;

  assign imem_rdata = 32'hA000_0000 | {22'h0, imem_addr};

  fetch_stage #(.PC_RESET(32'h0000_0000), .IMEM_ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_instr(id_instr), .id_op(id_op), .id_func(id_func), .id_rt(id_rt),
    .halted(halted), .cycle_count(cycle_count), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  // DUT 2: reset PC near the top of the address space, free running
  logic        rst2_n = 1'b0;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;
  logic [9:0]  imem_addr2;
  logic [31:0] imem_rdata2, pc2, id_pc2, id_pc_plus4_2, id_instr2;
  logic        id_valid2, halted2;
  logic [5:0]  id_op2, id_func2;
  logic [4:0]  id_rt2;
  logic [31:0] cycle_count2, stall_count2, flush_count2;
  logic        done2 = 1'b0;

  assign imem_rdata2 = 32'hA000_0000 | {22'h0, imem_addr2};

  fetch_stage #(.PC_RESET(32'hFFFF_FFF8), .IMEM_ADDR_W(10)) dut2 (
    .clk(clk), .rst_n(rst2_n), .stall(zero1), .flush(zero1),
    .redirect_valid(zero1), .redirect_pc(zero32), .halt(zero1),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .pc(pc2),
    .id_valid(id_valid2), .id_pc(id_pc2), .id_pc_plus4(id_pc_plus4_2),
    .id_instr(id_instr2), .id_op(id_op2), .id_func(id_func2), .id_rt(id_rt2),
    .halted(halted2), .cycle_count(cycle_count2), .stall_count(stall_count2),
    .flush_count(flush_count2)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic cmp_all(input exp_t e, input logic [31:0] a_pc, input logic [9:0] a_ia,
                         input logic a_v, input logic [31:0] a_i, input logic [5:0] a_op,
                         input logic [5:0] a_fn, input logic [4:0] a_rt,
                         input logic [31:0] a_idpc, input logic [31:0] a_p4, input logic a_h,
                         input logic [31:0] a_cc, input logic [31:0] a_sc, input logic [31:0] a_fc);
    chk({e.name, ".pc"},        a_pc,            e.pc);
    chk({e.name, ".imem_addr"}, {22'h0, a_ia},   {22'h0, e.pc[11:2]});
    chk({e.name, ".id_valid"},  {31'h0, a_v},    {31'h0, e.v});
    chk({e.name, ".id_instr"},  a_i,             e.instr);
    chk({e.name, ".id_op"},     {26'h0, a_op},   {26'h0, e.instr[31:26]});
    chk({e.name, ".id_func"},   {26'h0, a_fn},   {26'h0, e.instr[5:0]});
    chk({e.name, ".id_rt"},     {27'h0, a_rt},   {27'h0, e.instr[20:16]});
    chk({e.name, ".id_pc"},     a_idpc,          e.idpc);
    chk({e.name, ".id_pc_p4"},  a_p4,            e.p4);
    chk({e.name, ".halted"},    {31'h0, a_h},    {31'h0, e.h});
    chk({e.name, ".cycles"},    a_cc,            e.cc);
    chk({e.name, ".stalls"},    a_sc,            e.sc);
    chk({e.name, ".flushes"},   a_fc,            e.fc);
  endtask

  function automatic exp_t mk(input string n, input logic [31:0] epc, input logic ev,
                              input logic [31:0] ei, input logic [31:0] eidpc,
                              input logic [31:0] ep4, input logic eh, input logic [31:0] ecc,
                              input logic [31:0] esc, input logic [31:0] efc);
    exp_t e;
    e.name = n; e.pc = epc; e.v = ev; e.instr = ei; e.idpc = eidpc; e.p4 = ep4;
    e.h = eh; e.cc = ecc; e.sc = esc; e.fc = efc;
    return e;
  endfunction

  // Monitors
  initial forever begin
    @(posedge clk or negedge rst_n);
    #1;
    if (q1.size() > 0)
      cmp_all(q1.pop_front(), pc, imem_addr, id_valid, id_instr, id_op, id_func, id_rt,
              id_pc, id_pc_plus4, halted, cycle_count, stall_count, flush_count);
  end

  initial forever begin
    @(posedge clk or negedge rst2_n);
    #1;
    if (q2.size() > 0)
      cmp_all(q2.pop_front(), pc2, imem_addr2, id_valid2, id_instr2, id_op2, id_func2,
              id_rt2, id_pc2, id_pc_plus4_2, halted2, cycle_count2, stall_count2,
              flush_count2);
  end

  // Drive one edge of DUT 1 and queue the state expected right after it.
  task automatic step(input string n, input logic st, input logic fl, input logic rv,
                      input logic [31:0] rpc, input logic hl, input logic [31:0] epc,
                      input logic ev, input logic [31:0] ei, input logic [31:0] eidpc,
                      input logic [31:0] ep4, input logic eh, input logic [31:0] ecc,
                      input logic [31:0] esc, input logic [31:0] efc);
    stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc; halt = hl;
    q1.push_back(mk(n, epc, ev, ei, eidpc, ep4, eh, ecc, esc, efc));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; state must clear without a clock edge.
  task automatic async_reset(input string n);
    #2;
    q1.push_back(mk(n, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0));
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // DUT 2 stimulus: PC wrap across 2^32
  initial begin
    q2.push_back(mk("wrap_rst", 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0));
    @(negedge clk);
    rst2_n = 1'b1;
    q2.push_back(mk("wrap_e1", 32'hFFFF_FFFC, 1'b1, 32'hA000_03FE, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0, 1, 0, 0));
    @(posedge clk); @(negedge clk);
    q2.push_back(mk("wrap_e2", 32'h0000_0000, 1'b1, 32'hA000_03FF, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 2, 0, 0));
    @(posedge clk); @(negedge clk);
    q2.push_back(mk("wrap_e3", 32'h0000_0004, 1'b1, 32'hA000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0, 3, 0, 0));
    @(posedge clk); @(negedge clk);
    done2 = 1'b1;
  end

  // DUT 1 stimulus
  initial begin
    q1.push_back(mk("por", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Free run over A0..A3
    step("run1", 0,0,0,0,0, 32'h04, 1, 32'hA000_0000, 32'h00, 32'h04, 0, 1, 0, 0);
    step("run2", 0,0,0,0,0, 32'h08, 1, 32'hA000_0001, 32'h04, 32'h08, 0, 2, 0, 0);
    step("run3", 0,0,0,0,0, 32'h0C, 1, 32'hA000_0002, 32'h08, 32'h0C, 0, 3, 0, 0);
    step("run4", 0,0,0,0,0, 32'h10, 1, 32'hA000_0003, 32'h0C, 32'h10, 0, 4, 0, 0);

    async_reset("rst_mid");

    // Two-cycle stall holding A1
    step("re1",    0,0,0,0,0, 32'h04, 1, 32'hA000_0000, 32'h00, 32'h04, 0, 1, 0, 0);
    step("re2",    0,0,0,0,0, 32'h08, 1, 32'hA000_0001, 32'h04, 32'h08, 0, 2, 0, 0);
    step("stall1", 1,0,0,0,0, 32'h08, 1, 32'hA000_0001, 32'h04, 32'h08, 0, 3, 1, 0);
    step("stall2", 1,0,0,0,0, 32'h08, 1, 32'hA000_0001, 32'h04, 32'h08, 0, 4, 2, 0);
    step("unstall",0,0,0,0,0, 32'h0C, 1, 32'hA000_0002, 32'h08, 32'h0C, 0, 5, 2, 0);

    // Redirect with misaligned target during a stall
    step("redir_st", 1,0,1,32'h0000_0043,0, 32'h40, 0, 32'h0, 32'h08, 32'h0C, 0, 6, 2, 1);
    step("redir_nx", 0,0,0,0,0,              32'h44, 1, 32'hA000_0010, 32'h40, 32'h44, 0, 7, 2, 1);

    // Flush with stall: squash, PC holds
    step("flush_st", 1,1,0,0,0, 32'h44, 0, 32'h0, 32'h40, 32'h44, 0, 8, 2, 2);
    step("flush_nx", 0,0,0,0,0, 32'h48, 1, 32'hA000_0011, 32'h44, 32'h48, 0, 9, 2, 2);

    // Move to 0x14, then halt coincident with a redirect
    step("to10",  0,0,1,32'h0000_0010,0, 32'h10, 0, 32'h0, 32'h44, 32'h48, 0, 10, 2, 3);
    step("to14",  0,0,0,0,0,              32'h14, 1, 32'hA000_0004, 32'h10, 32'h14, 0, 11, 2, 3);
    step("halt",  0,0,1,32'h0000_0100,1,  32'h14, 0, 32'h0, 32'h10, 32'h14, 1, 12, 2, 3);
    for (int i = 0; i < 10; i++)
      step("frozen", i[0], i[1], i[2], 32'h200, 0, 32'h14, 0, 32'h0, 32'h10, 32'h14, 1, 12, 2, 3);

    // Async reset while halted and stalled
    stall = 1'b1;
    async_reset("rst_halt");
    step("restart1", 0,0,0,0,0, 32'h04, 1, 32'hA000_0000, 32'h00, 32'h04, 0, 1, 0, 0);
    step("restart2", 0,0,0,0,0, 32'h08, 1, 32'hA000_0001, 32'h04, 32'h08, 0, 2, 0, 0);

    for (int i = 0; i < 20 && !done2; i++) @(negedge clk);
    chk("dut2_done", {31'h0, done2}, 32'h1);
    repeat (2) @(negedge clk);
    chk("q1_drained", q1.size(), 32'h0);
    chk("q2_drained", q2.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
